text_lcd: RTL and testbench
===========================

TEXT_LCD -- requirements
Module: text_lcd

Interface
REQ-001 Parameter STEP_CYCLES, default 20, SHALL set the clk cycles per LCD step; board builds override it to at least 2000 (40 us at 50 MHz).
REQ-002 clk  input  1  SHALL be the single 50 MHz clock, rising-edge active.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 payload_in  input  8  SHALL be the frame payload; only bits [3:0] are displayed.
REQ-005 addr_in  input  8  SHALL carry {DST[7:4], SRC[3:0]}.
REQ-006 lcd_enb  output  1  SHALL be the LCD E strobe.
REQ-007 lcd_rs  output  1  SHALL be the register select: 0 = command, 1 = character data.
REQ-008 lcd_rw  output  1  SHALL be held at 0 (write only).
REQ-009 lcd_data  output  8  SHALL be the LCD DB[7:0] bus.

Function
REQ-010 A prescaler SHALL count 0..STEP_CYCLES-1 and wrap to 0; each wrap ends one step.
REQ-011 The 5-bit register counter SHALL increment once per step, and SHALL clear to 0 on every state transition.
REQ-012 The 3-bit register state SHALL use these encodings: DELAY=0, FUNCTION_SET=1, DISP_ONOFF=2, ENTRY_MODE=3, CLEAR_DISP=4, LINE1=5, LINE2=6, DELAY_T=7.
REQ-013 DELAY SHALL last 8 steps with no strobe, then go to FUNCTION_SET.
REQ-014 FUNCTION_SET, DISP_ONOFF and ENTRY_MODE SHALL last 1 step each, with rs=0 and data 0x38, 0x0C and 0x06 respectively.
REQ-015 CLEAR_DISP SHALL last 4 steps: data 0x01, rs=0, strobed in step 0 only; it then goes to LINE1.
REQ-016 LINE1 SHALL last 17 steps: step 0 sends command 0x80 (rs=0); steps 1..16 send line-1 characters 0..15 (rs=1).
REQ-017 LINE2 SHALL last 17 steps: step 0 sends command 0xC0 (rs=0); steps 1..16 send line-2 characters (rs=1).
REQ-018 DELAY_T SHALL last 4 steps with no strobe, then return to LINE1; the refresh loop is therefore 38 steps with no re-clear.
REQ-019 Line 1 SHALL read "SRC:s DST:d" followed by 5 spaces, where s = hex(addr_in[3:0]) and d = hex(addr_in[7:4]).
REQ-020 Line 2 SHALL read "PAYLOAD:p" followed by 7 spaces, where p = hex(payload_in[3:0]).
REQ-021 hex(n) SHALL be ASCII '0'+n for n = 0..9 and 'A'+n-10 for n = 10..15, always uppercase.
REQ-022 addr_in and payload_in SHALL be captured into internal registers on the clk edge entering LINE1 step 0; input changes mid-refresh appear on the next refresh only (no tearing).
REQ-023 In strobed steps, lcd_enb SHALL be 1 while the prescaler is in [STEP_CYCLES/4, 3*STEP_CYCLES/4) and 0 otherwise; rs and data SHALL be stable for the whole step.
REQ-024 In non-strobed steps, lcd_enb SHALL be 0, rs SHALL be 0 and data SHALL be 0x00.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst=0, the block SHALL force state=DELAY, counter=0, prescaler=0, lcd_enb=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00 and the captured inputs to 0x00.
REQ-027 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL restart from DELAY with full re-initialisation.

Structure
REQ-028 Package text_lcd_pkg SHALL hold the state enumeration, the command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) and the hex-to-ASCII function.
REQ-029 Sub-module text_lcd_prescaler SHALL generate the step-end pulse and the strobe-window signal; the FSM and character ROM stay in text_lcd.

Verification
REQ-030 Reset/idle: rst=0 for 100 ns -> all outputs 0, state=0, counter=0; after release, no lcd_enb pulse during the 8 DELAY steps.
REQ-031 Init sequence: after reset, the strobed bytes in order with rs=0 SHALL be 0x38, 0x0C, 0x06, 0x01, 0x80.
REQ-032 Display content: addr_in=0xCA, payload_in=0x05 -> line-1 bytes "SRC:A DST:C" + 5 spaces; then 0xC0; then "PAYLOAD:5" + 7 spaces (rs=1 on characters).
REQ-033 Refresh loop: within 50 us at STEP_CYCLES=20, at least 2 full LINE1/LINE2 passes SHALL occur, with 0x01 not repeated after the initial clear.
REQ-034 Input latch: change addr_in from 0xCA to 0x3F during LINE2 -> current pass unchanged; the next line 1 reads "SRC:F DST:3".
REQ-035 Mid-operation reset: assert rst=0 in LINE2 -> outputs go to 0 immediately without waiting for a clock; after release, the init sequence repeats from 0x38.

Source files
------------

// File: rtl/text_lcd_pkg.sv
// Shared definitions for the HD44780-style text LCD driver: controller states,
// command bytes and per-state step counts.
package text_lcd_pkg;

   typedef enum logic [2:0] {
      ST_DELAY        = 3'd0,
      ST_FUNCTION_SET = 3'd1,
      ST_DISP_ONOFF   = 3'd2,
      ST_ENTRY_MODE   = 3'd3,
      ST_CLEAR_DISP   = 3'd4,
      ST_LINE1        = 3'd5,
      ST_LINE2        = 3'd6,
      ST_DELAY_T      = 3'd7
   } state_e;

   localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ONOFF   = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
   localparam logic [7:0] CMD_CLEAR        = 8'h01;
   localparam logic [7:0] CMD_LINE1        = 8'h80;
   localparam logic [7:0] CMD_LINE2        = 8'hC0;
   localparam logic [7:0] ASCII_SPACE      = 8'h20;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'd0, n};
      return 8'h37 + {4'd0, n};   // 'A' - 10
   endfunction

   // Index of the final step spent in each state.
   function automatic logic [4:0] last_step(input state_e s);
      case (s)
         ST_DELAY:                  return 5'd7;
         ST_CLEAR_DISP, ST_DELAY_T: return 5'd3;
         ST_LINE1, ST_LINE2:        return 5'd16;
         default:                   return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/text_lcd_prescaler.sv
// Step timebase: a wrapping 0..STEP_CYCLES-1 counter, its end-of-step pulse and
// the E-strobe window evaluated on the count the register is about to take.
module text_lcd_prescaler #(
   parameter int STEP_CYCLES = 20
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic step_end_o,
   output logic win_next_o
);

   localparam int              CW   = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0]   LAST = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0]   LO   = CW'(STEP_CYCLES / 4);
   localparam logic [CW-1:0]   HI   = CW'((3 * STEP_CYCLES) / 4);

   logic [CW-1:0] cnt_q, cnt_d;

   assign step_end_o = (cnt_q == LAST);
   assign cnt_d      = step_end_o ? '0 : cnt_q + CW'(1);
   // Look-ahead lets the parent register lcd_enb in phase with cnt_q.
   assign win_next_o = (cnt_d >= LO) && (cnt_d < HI);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/text_lcd.sv
// Text LCD driver: one-time controller init, then an endless two-line refresh
// showing SRC/DST address nibbles and the payload nibble in hex.
module text_lcd
   import text_lcd_pkg::*;
#(
   parameter int STEP_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] payload_in,
   input  logic [7:0] addr_in,
   output logic       lcd_enb,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   state_e     state_q, state_d;
   logic [4:0] counter_q, counter_d;
   logic [7:0] addr_q, addr_d, pay_q, pay_d;
   logic       enb_q, enb_d, rs_q, rs_d;
   logic [7:0] data_q, data_d;
   logic       step_end, win_next, strobe;
   logic [3:0] char_idx;

   function automatic logic [7:0] line1_char(input logic [3:0] i, input logic [7:0] a);
      case (i)
         4'd0:    return "S";
         4'd1:    return "R";
         4'd2:    return "C";
         4'd3:    return ":";
         4'd4:    return hex_ascii(a[3:0]);
         4'd6:    return "D";
         4'd7:    return "S";
         4'd8:    return "T";
         4'd9:    return ":";
         4'd10:   return hex_ascii(a[7:4]);
         default: return ASCII_SPACE;
      endcase
   endfunction

   function automatic logic [7:0] line2_char(input logic [3:0] i, input logic [7:0] p);
      case (i)
         4'd0:    return "P";
         4'd1:    return "A";
         4'd2:    return "Y";
         4'd3:    return "L";
         4'd4:    return "O";
         4'd5:    return "A";
         4'd6:    return "D";
         4'd7:    return ":";
         4'd8:    return hex_ascii(p[3:0]);
         default: return ASCII_SPACE;
      endcase
   endfunction

   text_lcd_prescaler #(.STEP_CYCLES(STEP_CYCLES)) u_presc (
      .clk_i      (clk),
      .rst_ni     (rst),
      .step_end_o (step_end),
      .win_next_o (win_next)
   );

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      if (step_end) begin
         if (counter_q == last_step(state_q)) begin
            counter_d = '0;
            case (state_q)
               ST_DELAY:        state_d = ST_FUNCTION_SET;
               ST_FUNCTION_SET: state_d = ST_DISP_ONOFF;
               ST_DISP_ONOFF:   state_d = ST_ENTRY_MODE;
               ST_ENTRY_MODE:   state_d = ST_CLEAR_DISP;
               ST_CLEAR_DISP:   state_d = ST_LINE1;
               ST_LINE1:        state_d = ST_LINE2;
               ST_LINE2:        state_d = ST_DELAY_T;
               ST_DELAY_T:      state_d = ST_LINE1;
               default:         state_d = ST_DELAY;
            endcase
         end else begin
            counter_d = counter_q + 5'd1;
         end
      end
   end

   // Inputs are frozen once per refresh so a pass never mixes old and new values.
   always_comb begin
      addr_d = addr_q;
      pay_d  = pay_q;
      if (state_d == ST_LINE1 && state_q != ST_LINE1) begin
         addr_d = addr_in;
         pay_d  = payload_in;
      end
   end

   // Output bytes are decoded for the step being entered so they are registered.
   always_comb begin
      strobe   = 1'b0;
      rs_d     = 1'b0;
      data_d   = 8'h00;
      char_idx = counter_d[3:0] - 4'd1;
      case (state_d)
         ST_FUNCTION_SET: begin strobe = 1'b1; data_d = CMD_FUNCTION_SET; end
         ST_DISP_ONOFF:   begin strobe = 1'b1; data_d = CMD_DISP_ONOFF;   end
         ST_ENTRY_MODE:   begin strobe = 1'b1; data_d = CMD_ENTRY_MODE;   end
         ST_CLEAR_DISP: begin
            if (counter_d == 5'd0) begin
               strobe = 1'b1;
               data_d = CMD_CLEAR;
            end
         end
         ST_LINE1: begin
            strobe = 1'b1;
            if (counter_d == 5'd0) data_d = CMD_LINE1;
            else begin rs_d = 1'b1; data_d = line1_char(char_idx, addr_q); end
         end
         ST_LINE2: begin
            strobe = 1'b1;
            if (counter_d == 5'd0) data_d = CMD_LINE2;
            else begin rs_d = 1'b1; data_d = line2_char(char_idx, pay_q); end
         end
         default: ;
      endcase
      enb_d = strobe & win_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_DELAY;
         counter_q <= '0;
         addr_q    <= '0;
         pay_q     <= '0;
         enb_q     <= 1'b0;
         rs_q      <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         addr_q    <= addr_d;
         pay_q     <= pay_d;
         enb_q     <= enb_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
      end
   end

   assign lcd_enb  = enb_q;
   assign lcd_rs   = rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_data = data_q;

endmodule

// File: tb/tb_text_lcd.sv
// Bench for text_lcd: strobed bus traffic is compared with a string-built
// model of the expected display stream under randomized input updates.
`timescale 1ns/1ps
module tb_text_lcd;

   localparam int STEP  = 20;
   localparam int WIDTH = (3 * STEP) / 4 - STEP / 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] payload_in, addr_in;
   logic       lcd_enb, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   typedef struct {logic rs; logic [7:0] d; int cy;}  stb_t;
   typedef struct {logic rs; logic [7:0] d; int gap;} exp_t;

   stb_t  got_q[$];
   exp_t  exp_q[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    last_cy = -1;
   string hexs = "0123456789ABCDEF";

   text_lcd #(.STEP_CYCLES(STEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .payload_in (payload_in),
      .addr_in    (addr_in),
      .lcd_enb    (lcd_enb),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_data   (lcd_data)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: logs every E pulse with its byte and start cycle.
   initial begin
      logic       in_pulse;
      int         width;
      logic [8:0] rise_val;
      in_pulse = 1'b0;
      width    = 0;
      rise_val = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            in_pulse = 1'b0;
            width    = 0;
         end else if (lcd_enb) begin
            if (!in_pulse) begin
               in_pulse = 1'b1;
               width    = 1;
               rise_val = {lcd_rs, lcd_data};
               got_q.push_back(stb_t'{lcd_rs, lcd_data, cyc});
               check("rw_low", 32'(lcd_rw), 32'd0);
            end else begin
               width++;
            end
         end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("enb_width", width, WIDTH);
            check("byte_hold", 32'({lcd_rs, lcd_data}), 32'(rise_val));
         end
      end
   end

   task automatic expect_item(input string tag, input logic rs, input logic [7:0] d, input int gap);
      stb_t s;
      int   n = 0;
      while (got_q.size() == 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (got_q.size() == 0) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      s = got_q.pop_front();
      check({tag, "_rs"}, 32'(s.rs), 32'(rs));
      check({tag, "_data"}, 32'(s.d), 32'(d));
      if (gap > 0 && last_cy >= 0) check({tag, "_gap"}, s.cy - last_cy, gap * STEP);
      last_cy = s.cy;
   endtask

   function automatic void build_pass(input logic [7:0] a, input logic [7:0] p, input int first_gap);
      string l1, l2;
      l1 = {"SRC:", hexs.substr(int'(a[3:0]), int'(a[3:0])), " DST:",
            hexs.substr(int'(a[7:4]), int'(a[7:4])), "     "};
      l2 = {"PAYLOAD:", hexs.substr(int'(p[3:0]), int'(p[3:0])), "       "};
      exp_q.delete();
      exp_q.push_back(exp_t'{1'b0, 8'h80, first_gap});
      for (int i = 0; i < 16; i++) exp_q.push_back(exp_t'{1'b1, l1[i], 1});
      exp_q.push_back(exp_t'{1'b0, 8'hC0, 1});
      for (int i = 0; i < 16; i++) exp_q.push_back(exp_t'{1'b1, l2[i], 1});
   endfunction

   task automatic run_pass(input string nm, input logic [7:0] a, input logic [7:0] p,
                           input int first_gap, input int change_at,
                           input logic [7:0] na, input logic [7:0] np, input int stop_at);
      build_pass(a, p, first_gap);
      for (int i = 0; i < exp_q.size() && i < stop_at; i++) begin
         expect_item($sformatf("%s_b%0d", nm, i), exp_q[i].rs, exp_q[i].d, exp_q[i].gap);
         if (i == change_at) begin
            addr_in    = na;
            payload_in = np;
         end
      end
   endtask

   task automatic expect_init(input string nm);
      expect_item({nm, "_fs"},  1'b0, 8'h38, 0);
      expect_item({nm, "_on"},  1'b0, 8'h0C, 1);
      expect_item({nm, "_em"},  1'b0, 8'h06, 1);
      expect_item({nm, "_clr"}, 1'b0, 8'h01, 1);
   endtask

   initial begin
      logic [7:0] ca, cp, na, np;
      logic       pre_enb;
      time        t_rel;
      rst        = 1'b0;
      addr_in    = 8'hCA;
      payload_in = 8'h05;
      #95;
      check("rst_enb",   32'(lcd_enb), 32'd0);
      check("rst_rs",    32'(lcd_rs), 32'd0);
      check("rst_rw",    32'(lcd_rw), 32'd0);
      check("rst_data",  32'(lcd_data), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'd0);
      check("rst_cnt",   32'(dut.counter_q), 32'd0);
      check("rst_presc", 32'(dut.u_presc.cnt_q), 32'd0);
      check("rst_addr",  32'(dut.addr_q), 32'd0);
      check("rst_pay",   32'(dut.pay_q), 32'd0);
      #5 rst = 1'b1;
      t_rel = $time;

      repeat (8 * STEP) @(posedge clk);
      #1;
      check("delay_no_strobe", got_q.size(), 0);
      check("delay_to_fs", 32'(dut.state_q), 32'd1);

      expect_init("init");
      repeat (2 * STEP) @(negedge clk);
      check("clr_idle_data", 32'(lcd_data), 32'd0);
      check("clr_idle_rs",   32'(lcd_rs), 32'd0);

      ca = 8'hCA;
      cp = 8'h05;
      run_pass("p0", ca, cp, 4, 20, 8'h3F, 8'h05, 99);
      ca = 8'h3F;

      for (int k = 1; k <= 4; k++) begin
         na = 8'($urandom);
         np = 8'($urandom);
         run_pass($sformatf("p%0d", k), ca, cp, 5, int'($urandom_range(33, 1)), na, np, 99);
         ca = na;
         cp = np;
         if (k == 1) check("loop_time", 32'(($time - t_rel) <= 50000), 32'd1);
         repeat (2 * STEP) @(negedge clk);
         check($sformatf("dt_idle_data%0d", k), 32'(lcd_data), 32'd0);
         check($sformatf("dt_idle_rs%0d", k),   32'(lcd_rs), 32'd0);
      end

      run_pass("p5", ca, cp, 5, 99, 8'h00, 8'h00, 18);
      pre_enb = lcd_enb;
      #3 rst = 1'b0;
      #1;
      check("mid_pre_enb", 32'(pre_enb), 32'd1);
      check("mid_enb",   32'(lcd_enb), 32'd0);
      check("mid_rs",    32'(lcd_rs), 32'd0);
      check("mid_data",  32'(lcd_data), 32'd0);
      check("mid_state", 32'(dut.state_q), 32'd0);
      check("mid_cnt",   32'(dut.counter_q), 32'd0);
      #100;
      got_q.delete();
      last_cy = -1;
      rst = 1'b1;

      expect_init("reinit");
      run_pass("r0", ca, cp, 4, 99, 8'h00, 8'h00, 99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
